serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes d = a - b - bin over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation companion to the team's gate-level adder cells.
- It is used where area matters more than latency.
- The result is captured into a holding register and signalled with a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor. It computes d = a - b - bin (modulo 2^WIDTH) LSB first
// over WIDTH clock cycles. It uses one full-subtractor cell and a registered
// borrow. The finished difference is loaded into a holding register, and a
// one-cycle done pulse announces it.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a      in   WIDTH  minuend, sampled on an accepted start
//   b      in   WIDTH  subtrahend, sampled on an accepted start
//   bin    in   1      borrow-in, sampled on an accepted start
//   busy   out  1      high while bits are being shifted (WIDTH cycles)
//   done   out  1      one-cycle pulse; results valid from this cycle onward
//   d      out  WIDTH  difference (holding register)
//   bout   out  1      unsigned borrow-out (a < b + bin)
//   ovf    out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    // One extra bit means the counter never wraps, even for power-of-two widths.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell working on the current LSBs.
    logic             x_bit, y_bit, diff_bit, br_new;
    logic [WIDTH-1:0] sr_shift;

    assign x_bit    = sa_q[0];
    assign y_bit    = sb_q[0];
    assign diff_bit = x_bit ^ y_bit ^ br_q;
    assign br_new   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    assign sr_shift = {diff_bit, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            // DONE accepts a new start exactly like IDLE does. That is how
            // back-to-back operation avoids an idle gap.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_shift;
                br_d  = br_new;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the MSB, br_q is the borrow into the sign bit. If it
                    // differs from the borrow out, the signed result overflowed.
                    res_d   = sr_shift;
                    bout_d  = br_new;
                    ovf_d   = br_q ^ br_new;
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign d    = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done, bout, ovf;
    logic [7:0] d;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: unsigned difference for d/bout, signed arithmetic for ovf.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        exp_t       r;
        logic [8:0] full;
        int         s;
        full   = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
        s      = int'($signed(ma)) - int'($signed(mb)) - (mbin ? 1 : 0);
        r.d    = full[7:0];
        r.bout = full[8];
        r.ovf  = (s < -128) || (s > 127);
        return r;
    endfunction

    task automatic finish_bench();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // Drive one start with the given operands and push the expected result.
    // The task returns #1 after the accepting edge, with start already low.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input exp_t e);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        $display("op a=%02h b=%02h bin=%0b expect d=%02h bout=%0b ovf=%0b", ia, ib, ibin, e.d, e.bout, e.ovf);
    endtask

    // Count edges from the accepting edge until done. Also count busy cycles.
    task automatic wait_done(output int lat, output int bcnt, output bit to);
        lat  = 0;
        bcnt = 0;
        to   = 1'b0;
        if (busy) bcnt++;
        while (!done) begin
            if (lat >= 40) begin
                to = 1'b1;
                return;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, d, bout, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b d=%02h bout=%b ovf=%b, required all 0", busy, done, d, bout, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, d, bout, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b d=%02h, required all 0", busy, done, d);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta[5]  = '{8'h35, 8'h00, 8'h10, 8'h80, 8'h7F};
        logic [7:0] tb_[5] = '{8'h12, 8'h01, 8'h0F, 8'h01, 8'hFF};
        logic       tbi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t       te[5]  = '{'{8'h23, 1'b0, 1'b0}, '{8'hFF, 1'b1, 1'b0},
                               '{8'h00, 1'b0, 1'b0}, '{8'h7F, 1'b0, 1'b1},
                               '{8'h80, 1'b1, 1'b1}};
        int lat, bcnt;
        bit to;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb_[i], tbi[i], te[i]);
            wait_done(lat, bcnt, to);
            if (to) begin
                n_cmp++; n_fail++;
                $display("FAIL directed_timeout: got no done within 40 cycles, required done at 8");
                finish_bench();
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, bout, ovf} !== e) begin
                n_fail++;
                $display("FAIL directed_%0d: got d=%02h bout=%b ovf=%b, required d=%02h bout=%b ovf=%b",
                         i, d, bout, ovf, e.d, e.bout, e.ovf);
            end
            n_cmp++;
            if (lat !== 8 || bcnt !== 8) begin
                n_fail++;
                $display("FAIL directed_timing_%0d: got latency=%0d busy_cycles=%0d, required 8/8", i, lat, bcnt);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse_%0d: got done=%b busy=%b after DONE, required 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        bit to;
        exp_t e;
        logic [7:0] na, nb;
        logic       nbin;
        na = 8'h5A; nb = 8'hA5; nbin = 1'b1;
        a = na; b = nb; bin = nbin; start = 1'b1;
        exp_q.push_back(model(na, nb, nbin));
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            // Operands are don't-care while busy; scramble them to prove it.
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            wait_done(lat, bcnt, to);
            if (to) begin
                n_cmp++; n_fail++;
                $display("FAIL b2b_timeout: got no done within 40 cycles, required done at 8");
                finish_bench();
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, bout, ovf} !== e || lat !== 8) begin
                n_fail++;
                $display("FAIL b2b_%0d: got d=%02h bout=%b ovf=%b lat=%0d, required d=%02h bout=%b ovf=%b lat=8",
                         k, d, bout, ovf, lat, e.d, e.bout, e.ovf);
            end
            na = 8'($urandom); nb = 8'($urandom); nbin = 1'($urandom);
            a = na; b = nb; bin = nbin;
            if (k == 5) start = 1'b0;
            else exp_q.push_back(model(na, nb, nbin));
            $display("b2b op %0d done d=%02h, next a=%02h b=%02h bin=%0b", k, d, na, nb, nbin);
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== (k != 5) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap_%0d: got busy=%b done=%b after DONE, required busy=%0b done=0", k, busy, done, k != 5);
            end
        end
    endtask

    task automatic test_start_during_busy();
        logic [7:0] prev_d;
        exp_t e;
        prev_d = d;
        issue(8'h35, 8'h12, 1'b0, model(8'h35, 8'h12, 1'b0));
        for (int c = 1; c <= 7; c++) begin
            start = (c % 2) == 1;
            a = 8'hFF; b = 8'h00; bin = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (d !== prev_d || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ignore_%0d: got d=%02h done=%b busy=%b, required d=%02h done=0 busy=1",
                         c, d, done, busy, prev_d);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || {d, bout, ovf} !== e) begin
            n_fail++;
            $display("FAIL busy_result: got done=%b d=%02h bout=%b ovf=%b, required done=1 d=%02h bout=%b ovf=%b",
                     done, d, bout, ovf, e.d, e.bout, e.ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_idle: got done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bcnt;
        bit to, seen_done;
        exp_t e;
        issue(8'h9C, 8'h27, 1'b0, model(8'h9C, 8'h27, 1'b0));
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, d, bout, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b done=%b d=%02h bout=%b ovf=%b, required all 0", busy, done, d, bout, ovf);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL reset_discard: got done/busy activity after reset, required none");
        end
        issue(8'h10, 8'h0F, 1'b1, model(8'h10, 8'h0F, 1'b1));
        wait_done(lat, bcnt, to);
        if (to) begin
            n_cmp++; n_fail++;
            $display("FAIL reset_recover_timeout: got no done within 40 cycles, required done at 8");
            finish_bench();
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({d, bout, ovf} !== e || lat !== 8) begin
            n_fail++;
            $display("FAIL reset_recover: got d=%02h bout=%b ovf=%b lat=%0d, required d=%02h bout=%b ovf=%b lat=8",
                     d, bout, ovf, lat, e.d, e.bout, e.ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit to;
        exp_t e;
        logic [7:0] ra, rb;
        logic       rbin;
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            issue(ra, rb, rbin, model(ra, rb, rbin));
            wait_done(lat, bcnt, to);
            if (to) begin
                n_cmp++; n_fail++;
                $display("FAIL random_timeout: got no done within 40 cycles, required done at 8");
                finish_bench();
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({d, bout, ovf} !== e || lat !== 8 || bcnt !== 8) begin
                n_fail++;
                $display("FAIL random_%0d: got d=%02h bout=%b ovf=%b lat=%0d busy=%0d, required d=%02h bout=%b ovf=%b lat=8 busy=8",
                         i, d, bout, ovf, lat, bcnt, e.d, e.bout, e.ovf);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL random_pulse_%0d: got done=%b one cycle later, required 0", i, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_during_busy();
        test_reset_mid_op();
        test_random();
        finish_bench();
    end

endmodule
